aqed_lb_checker: RTL
====================

// Module: aqed_lb_checker
// PURPOSE
//  Parametrised A-QED wrapper for the line-buffer memory core. It sits between the formal stimulus and
//  the DUT data port, for NUM_CH lanes. It captures one "original" input, later re-injects it as a
//  "duplicate", and compares the two DUT outputs (functional consistency). It also flags a
//  response-bound violation when the original output is late.
// PARAMETERS
//  DATA_W     16  width of one lane
//  NUM_CH     1   lanes per transfer; all lanes move together under one valid
//  CNT_W      17  width of the input/output index counters; counters saturate at all-ones
//  DEPTH_W    16  width of the depth configuration input
//  BOUND_MULT 4   response bound = BOUND_MULT*depth accepted inputs after the original
// PORTS
//  clk           in   1              clock
//  reset         in   1              asynchronous, active-low reset
//  clk_en        in   1              global enable; all state holds when 0
//  depth         in   DEPTH_W        line-buffer depth; stable after reset, >=1
//  in_data       in   NUM_CH*DATA_W  stimulus data
//  in_valid      in   1              stimulus valid (one transfer per enabled cycle)
//  exec_dup      in   1              free formal input: selects original/duplicate issue
//  dut_in_data   out  NUM_CH*DATA_W  data to DUT data_in
//  dut_in_valid  out  1              write enable to DUT
//  dut_out_data  in   NUM_CH*DATA_W  DUT data_out
//  dut_out_valid in   1              DUT valid_out
//  orig_issued   out  1              sticky: original accepted
//  orig_done     out  1              sticky: original output captured
//  qed_done      out  1              sticky: duplicate output compared
//  qed_check     out  1              compare result, valid when qed_done=1
//  mismatch_mask out  NUM_CH         per-lane mismatch, valid when qed_done=1
//  bound_fail    out  1              sticky: response bound exceeded before orig_done
// BEHAVIOUR
//  - Reset (reset=0, async) clears every output, counter and register to 0; the FSM goes to IDLE.
//  - Pass-through: dut_in_valid=in_valid. dut_in_data=in_data, except in DUP_ISSUE (see below).
//    Combinational, zero latency.
//  - in_cnt increments on each accepted input (clk_en&in_valid); out_cnt increments on clk_en&dut_out_valid.
//    The DUT preserves order, so output k corresponds to input k.
//  - FSM (advances only when clk_en=1):
//    IDLE -> ORIG: on in_valid&exec_dup&in_cnt!=max. Latch orig_data=in_data and orig_idx=in_cnt;
//      orig_issued=1 from the next cycle.
//    ORIG -> WAIT_DUP: on dut_out_valid&out_cnt==orig_idx. Latch orig_out; orig_done=1.
//    ORIG/WAIT_DUP: in_valid&exec_dup issues the duplicate in the same cycle. dut_in_data=orig_data,
//      dup_idx=in_cnt, dup_seen=1. Allowed only once; a later exec_dup is ignored.
//    Once dup_seen=1 and orig_done=1, the next dut_out_valid with out_cnt==dup_idx compares
//      dut_out_data to orig_out lane by lane. Result: qed_done=1, qed_check=&~mismatch_mask,
//      FSM -> DONE.
//    DONE holds until reset; outputs are frozen.
//  - The duplicate may be issued before orig_done. Its compare then waits for the original capture;
//    dup_idx>orig_idx always, so the order is guaranteed.
//  - The original output and the duplicate input may land in the same cycle; both actions happen.
//  - Response bound: aft_cnt counts accepted inputs while orig_issued&~orig_done, saturating at CNT_W ones.
//    bound_fail sets when aft_cnt >= BOUND_MULT*depth and orig_done=0.
//    The product is computed in DEPTH_W+$clog2(BOUND_MULT)+1 bits with no truncation.
//  - Saturation: if in_cnt is at max, exec_dup is ignored in IDLE. A saturated out_cnt never matches.
//  - clk_en=0: no counter, FSM or sticky update. Pass-through stays combinational.
//  - exec_dup without in_valid has no effect.
// TESTING
//  1 NUM_CH=1, depth=4, identity-delay DUT model: inputs 0x11..0x18, exec_dup on input 2 (0x13) and
//    input 6 -> dut_in_data=0x13 at idx6; qed_done=1 and qed_check=1 after output 6; bound_fail=0.
//  2 Same stimulus, DUT model corrupts output 6 to 0x14 -> qed_done=1, qed_check=0, mismatch_mask=1.
//  3 NUM_CH=2, depth=2, lane1 corrupted only -> mismatch_mask=2'b10, qed_check=0.
//  4 depth=2, BOUND_MULT=4, DUT stalls dut_out_valid=0 after original, 8 more inputs ->
//    bound_fail=1 on the cycle after the 8th; 7 inputs -> bound_fail=0.
//  5 Orig output and duplicate input in the same cycle; clk_en=0 for 3 cycles mid-run ->
//    counters and FSM hold, final qed_check=1.
//  6 Reset asserted async in WAIT_DUP -> all outputs 0 immediately, FSM IDLE; a new orig/dup pair
//    afterwards completes with qed_check=1.

Source files
------------

// File: rtl/aqed_lb_checker_if.sv
// Signal bundle between the formal stimulus, the A-QED checker and the line-buffer data port.
// The checker uses the slave view; the stimulus/DUT side uses the master view.
interface aqed_lb_checker_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_CH = 1
);
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     exec_dup;
    logic [NUM_CH*DATA_W-1:0] dut_in_data;
    logic                     dut_in_valid;
    logic [NUM_CH*DATA_W-1:0] dut_out_data;
    logic                     dut_out_valid;
    logic                     orig_issued;
    logic                     orig_done;
    logic                     qed_done;
    logic                     qed_check;
    logic [NUM_CH-1:0]        mismatch_mask;
    logic                     bound_fail;

    modport master (
        output in_data, in_valid, exec_dup, dut_out_data, dut_out_valid,
        input  dut_in_data, dut_in_valid, orig_issued, orig_done, qed_done, qed_check,
               mismatch_mask, bound_fail
    );

    modport slave (
        input  in_data, in_valid, exec_dup, dut_out_data, dut_out_valid,
        output dut_in_data, dut_in_valid, orig_issued, orig_done, qed_done, qed_check,
               mismatch_mask, bound_fail
    );
endinterface

// File: rtl/aqed_lb_checker.sv
// A-QED functional-consistency and response-bound checker wrapped around a line-buffer core.
// Captures one original transfer, re-injects it as a duplicate and compares both outputs.
module aqed_lb_checker #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned NUM_CH     = 1,
    parameter int unsigned CNT_W      = 17,
    parameter int unsigned DEPTH_W    = 16,
    parameter int unsigned BOUND_MULT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic [DEPTH_W-1:0] depth,
    aqed_lb_checker_if.slave   bus
);
    localparam int unsigned W     = NUM_CH * DATA_W;
    localparam int unsigned ProdW = DEPTH_W + $clog2(BOUND_MULT) + 1;
    localparam int unsigned CmpW  = (ProdW > CNT_W) ? ProdW : CNT_W;
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [1:0] {StIdle, StOrig, StWaitDup, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]   aft_cnt_q, aft_cnt_d;
    logic [CNT_W-1:0]   orig_idx_q, orig_idx_d;
    logic [CNT_W-1:0]   dup_idx_q, dup_idx_d;
    logic [W-1:0]       orig_data_q, orig_data_d;
    logic [W-1:0]       orig_out_q, orig_out_d;
    logic               dup_seen_q, dup_seen_d;
    logic               orig_issued_q, orig_issued_d;
    logic               orig_done_q, orig_done_d;
    logic               qed_done_q, qed_done_d;
    logic               qed_check_q, qed_check_d;
    logic [NUM_CH-1:0]  mismatch_mask_q, mismatch_mask_d;
    logic               bound_fail_q, bound_fail_d;

    logic               accept;
    logic               out_ev;
    logic               in_full;
    logic               out_ok;
    logic               dup_fire;
    logic [NUM_CH-1:0]  lane_diff;
    logic [ProdW-1:0]   bound_prod;

    assign bound_prod = ProdW'(depth) * ProdW'(BOUND_MULT);

    always_comb begin
        accept   = clk_en & bus.in_valid;
        out_ev   = clk_en & bus.dut_out_valid;
        in_full  = (in_cnt_q == CntMax);
        // A saturated output index is ambiguous, so it may never match a tracked index.
        out_ok   = (out_cnt_q != CntMax);
        dup_fire = accept & bus.exec_dup & ~dup_seen_q
                 & ((state_q == StOrig) | (state_q == StWaitDup));
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            lane_diff[i] = (bus.dut_out_data[i*DATA_W +: DATA_W] !=
                            orig_out_q[i*DATA_W +: DATA_W]);
        end
    end

    assign bus.dut_in_valid  = bus.in_valid;
    assign bus.dut_in_data   = dup_fire ? orig_data_q : bus.in_data;
    assign bus.orig_issued   = orig_issued_q;
    assign bus.orig_done     = orig_done_q;
    assign bus.qed_done      = qed_done_q;
    assign bus.qed_check     = qed_check_q;
    assign bus.mismatch_mask = mismatch_mask_q;
    assign bus.bound_fail    = bound_fail_q;

    always_comb begin
        state_d         = state_q;
        in_cnt_d        = in_cnt_q;
        out_cnt_d       = out_cnt_q;
        aft_cnt_d       = aft_cnt_q;
        orig_idx_d      = orig_idx_q;
        dup_idx_d       = dup_idx_q;
        orig_data_d     = orig_data_q;
        orig_out_d      = orig_out_q;
        dup_seen_d      = dup_seen_q;
        orig_issued_d   = orig_issued_q;
        orig_done_d     = orig_done_q;
        qed_done_d      = qed_done_q;
        qed_check_d     = qed_check_q;
        mismatch_mask_d = mismatch_mask_q;
        bound_fail_d    = bound_fail_q;

        if (accept && !in_full) begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
        end
        if (out_ev && out_ok) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end
        if (accept && orig_issued_q && !orig_done_q && aft_cnt_q != CntMax) begin
            aft_cnt_d = aft_cnt_q + CNT_W'(1);
        end
        if (dup_fire) begin
            dup_seen_d = 1'b1;
            dup_idx_d  = in_cnt_q;
        end

        unique case (state_q)
            StIdle: begin
                if (accept && bus.exec_dup && !in_full) begin
                    state_d       = StOrig;
                    orig_data_d   = bus.in_data;
                    orig_idx_d    = in_cnt_q;
                    orig_issued_d = 1'b1;
                end
            end
            StOrig: begin
                if (out_ev && out_ok && out_cnt_q == orig_idx_q) begin
                    orig_out_d  = bus.dut_out_data;
                    orig_done_d = 1'b1;
                    state_d     = StWaitDup;
                end
            end
            StWaitDup: begin
                if (dup_seen_q && out_ev && out_ok && out_cnt_q == dup_idx_q) begin
                    qed_done_d      = 1'b1;
                    mismatch_mask_d = lane_diff;
                    qed_check_d     = ~|lane_diff;
                    state_d         = StDone;
                end
            end
            StDone: begin
            end
            default: state_d = StIdle;
        endcase

        // Uses the updated count so the flag rises right after the offending input.
        if (clk_en && orig_issued_q && !orig_done_d &&
            CmpW'(aft_cnt_d) >= CmpW'(bound_prod)) begin
            bound_fail_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            in_cnt_q        <= '0;
            out_cnt_q       <= '0;
            aft_cnt_q       <= '0;
            orig_idx_q      <= '0;
            dup_idx_q       <= '0;
            orig_data_q     <= '0;
            orig_out_q      <= '0;
            dup_seen_q      <= 1'b0;
            orig_issued_q   <= 1'b0;
            orig_done_q     <= 1'b0;
            qed_done_q      <= 1'b0;
            qed_check_q     <= 1'b0;
            mismatch_mask_q <= '0;
            bound_fail_q    <= 1'b0;
        end else if (clk_en) begin
            state_q         <= state_d;
            in_cnt_q        <= in_cnt_d;
            out_cnt_q       <= out_cnt_d;
            aft_cnt_q       <= aft_cnt_d;
            orig_idx_q      <= orig_idx_d;
            dup_idx_q       <= dup_idx_d;
            orig_data_q     <= orig_data_d;
            orig_out_q      <= orig_out_d;
            dup_seen_q      <= dup_seen_d;
            orig_issued_q   <= orig_issued_d;
            orig_done_q     <= orig_done_d;
            qed_done_q      <= qed_done_d;
            qed_check_q     <= qed_check_d;
            mismatch_mask_q <= mismatch_mask_d;
            bound_fail_q    <= bound_fail_d;
        end
    end
endmodule
